// File: rtl/uart_host_if.sv
// uart_host_if: turns a valid/ready transmit byte stream into UART write strobes and polls
// RXRDY to issue UART read strobes, delivering received bytes plus error flags on a
// valid/ready output slot.
module uart_host_if #(
    parameter int unsigned TX_BLANK = 2,
    parameter int unsigned RX_BLANK = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    // transmit byte stream from the host
    input  logic       s_tx_valid,
    input  logic [7:0] s_tx_data,
    output logic       s_tx_ready,
    // received byte slot towards the consumer
    output logic       m_rx_valid,
    output logic [7:0] m_rx_data,
    output logic [2:0] m_rx_err,
    input  logic       m_rx_ready,
    output logic [7:0] err_count,
    // UART CPU strobe interface
    output logic       uart_csn,
    output logic       uart_wen,
    output logic       uart_oen,
    output logic [7:0] uart_wdata,
    input  logic [7:0] uart_rdata,
    input  logic       uart_txrdy,
    input  logic       uart_rxrdy,
    input  logic       uart_parity_err,
    input  logic       uart_framing_err,
    input  logic       uart_overflow
);

    localparam logic [3:0] TxBlankCnt = 4'(TX_BLANK);
    localparam logic [3:0] RxBlankCnt = 4'(RX_BLANK);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead
    } state_e;

    state_e     state_q;
    logic [3:0] tx_cnt_q;
    logic [3:0] rx_cnt_q;
    logic       last_tx_q;   // 1: last grant went to TX, 0: to RX (reset value)

    logic       tx_req;
    logic       rx_req;
    logic       grant_tx;
    logic       grant_rx;
    logic [2:0] rx_err;

    assign rx_err = {uart_framing_err, uart_parity_err, uart_overflow};

    // Request eligibility and round-robin arbitration, evaluated only in IDLE
    always_comb begin
        tx_req   = (state_q == StIdle) & s_tx_valid & uart_txrdy & (tx_cnt_q == 4'd0);
        rx_req   = (state_q == StIdle) & uart_rxrdy & (rx_cnt_q == 4'd0) &
                   (~m_rx_valid | m_rx_ready);
        // On a tie the side that did not win last time gets the grant
        grant_tx = tx_req & (~rx_req | ~last_tx_q);
        grant_rx = rx_req & (~tx_req | last_tx_q);
    end

    // Handshake is suppressed while reset is held so no byte is lost during reset
    assign s_tx_ready = grant_tx & RESET_N;

    // Main FSM: registered strobes, write data, receive slot and error counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            last_tx_q  <= 1'b0;
            uart_csn   <= 1'b1;
            uart_wen   <= 1'b1;
            uart_oen   <= 1'b1;
            uart_wdata <= 8'h00;
            m_rx_valid <= 1'b0;
            m_rx_data  <= 8'h00;
            m_rx_err   <= 3'b000;
            err_count  <= 8'h00;
        end else begin
            // A fill in READ below overrides this pop
            if (m_rx_valid && m_rx_ready) begin
                m_rx_valid <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (grant_tx) begin
                        state_q    <= StWrite;
                        last_tx_q  <= 1'b1;
                        uart_csn   <= 1'b0;
                        uart_wen   <= 1'b0;
                        uart_wdata <= s_tx_data;
                    end else if (grant_rx) begin
                        state_q   <= StRead;
                        last_tx_q <= 1'b0;
                        uart_csn  <= 1'b0;
                        uart_oen  <= 1'b0;
                    end
                end
                StWrite: begin
                    state_q  <= StIdle;
                    uart_csn <= 1'b1;
                    uart_wen <= 1'b1;
                end
                StRead: begin
                    state_q    <= StIdle;
                    uart_csn   <= 1'b1;
                    uart_oen   <= 1'b1;
                    m_rx_valid <= 1'b1;
                    m_rx_data  <= uart_rdata;
                    m_rx_err   <= rx_err;
                    if ((rx_err != 3'b000) && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    uart_csn <= 1'b1;
                    uart_wen <= 1'b1;
                    uart_oen <= 1'b1;
                end
            endcase
        end
    end

    // TX blank counter: reloads as the write strobe ends, then counts down to zero
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_cnt_q <= 4'd0;
        end else if (state_q == StWrite) begin
            tx_cnt_q <= TxBlankCnt;
        end else if (tx_cnt_q != 4'd0) begin
            tx_cnt_q <= tx_cnt_q - 4'd1;
        end
    end

    // RX blank counter: reloads as the read strobe ends, then counts down to zero
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_cnt_q <= 4'd0;
        end else if (state_q == StRead) begin
            rx_cnt_q <= RxBlankCnt;
        end else if (rx_cnt_q != 4'd0) begin
            rx_cnt_q <= rx_cnt_q - 4'd1;
        end
    end

endmodule

// File: tb/tb_uart_host_if.sv
// Self-checking bench for uart_host_if: a cycle-timestamp transaction model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_uart_host_if;

    localparam int unsigned TX_BLANK = 2;
    localparam int unsigned RX_BLANK = 2;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       s_tx_valid = 1'b0;
    logic [7:0] s_tx_data = 8'h00;
    logic       s_tx_ready;
    logic       m_rx_valid;
    logic [7:0] m_rx_data;
    logic [2:0] m_rx_err;
    logic       m_rx_ready = 1'b0;
    logic [7:0] err_count;
    logic       uart_csn;
    logic       uart_wen;
    logic       uart_oen;
    logic [7:0] uart_wdata;
    logic [7:0] uart_rdata = 8'h00;
    logic       uart_txrdy = 1'b0;
    logic       uart_rxrdy = 1'b0;
    logic       uart_parity_err = 1'b0;
    logic       uart_framing_err = 1'b0;
    logic       uart_overflow = 1'b0;

    always #5 CLK = ~CLK;

    uart_host_if #(
        .TX_BLANK(TX_BLANK),
        .RX_BLANK(RX_BLANK)
    ) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .s_tx_valid      (s_tx_valid),
        .s_tx_data       (s_tx_data),
        .s_tx_ready      (s_tx_ready),
        .m_rx_valid      (m_rx_valid),
        .m_rx_data       (m_rx_data),
        .m_rx_err        (m_rx_err),
        .m_rx_ready      (m_rx_ready),
        .err_count       (err_count),
        .uart_csn        (uart_csn),
        .uart_wen        (uart_wen),
        .uart_oen        (uart_oen),
        .uart_wdata      (uart_wdata),
        .uart_rdata      (uart_rdata),
        .uart_txrdy      (uart_txrdy),
        .uart_rxrdy      (uart_rxrdy),
        .uart_parity_err (uart_parity_err),
        .uart_framing_err(uart_framing_err),
        .uart_overflow   (uart_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Time is tracked as cycle numbers: each side may be granted from its "free" cycle on.
    int         m_cyc;
    int         m_tx_free;
    int         m_rx_free;
    int         m_bus;        // transfer on the strobes this cycle: 0 none, 1 write, 2 read
    bit         m_tx_last;
    bit         m_v;
    logic [7:0] m_d;
    logic [2:0] m_e;
    int         m_errs;
    logic [7:0] m_wbyte;

    function automatic void m_reset();
        m_cyc = 0; m_tx_free = 0; m_rx_free = 0; m_bus = 0; m_tx_last = 1'b0;
        m_v = 1'b0; m_d = 8'h00; m_e = 3'b000; m_errs = 0; m_wbyte = 8'h00;
    endfunction

    function automatic void m_grants(output bit gtx, output bit grx);
        bit treq;
        bit rreq;
        treq = (m_bus == 0) && s_tx_valid && uart_txrdy && (m_cyc >= m_tx_free);
        rreq = (m_bus == 0) && uart_rxrdy && (m_cyc >= m_rx_free) && (!m_v || m_rx_ready);
        gtx  = treq && (!rreq || !m_tx_last);
        grx  = rreq && (!treq || m_tx_last);
    endfunction

    function automatic void m_step();
        bit gtx;
        bit grx;
        m_grants(gtx, grx);
        if (m_bus == 1) m_tx_free = m_cyc + 1 + int'(TX_BLANK);
        if (m_v && m_rx_ready) m_v = 1'b0;
        if (m_bus == 2) begin
            m_rx_free = m_cyc + 1 + int'(RX_BLANK);
            m_v = 1'b1;
            m_d = uart_rdata;
            m_e = {uart_framing_err, uart_parity_err, uart_overflow};
            if (m_e != 3'b000 && m_errs < 255) m_errs++;
        end
        if (gtx) begin
            m_wbyte   = s_tx_data;
            m_tx_last = 1'b1;
        end
        if (grx) m_tx_last = 1'b0;
        m_bus = gtx ? 1 : (grx ? 2 : 0);
        m_cyc++;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        bit gtx;
        bit grx;
        forever begin
            @(negedge CLK);
            if (RESET_N) begin
                m_grants(gtx, grx);
                chk("m_s_tx_ready", s_tx_ready, gtx);
                chk("m_uart_csn", uart_csn, m_bus == 0);
                chk("m_uart_wen", uart_wen, m_bus != 1);
                chk("m_uart_oen", uart_oen, m_bus != 2);
                chk("m_uart_wdata", uart_wdata, m_wbyte);
                chk("m_rx_valid", m_rx_valid, m_v);
                chk("m_rx_data", m_rx_data, m_d);
                chk("m_rx_err", m_rx_err, m_e);
                chk("m_err_count", err_count, m_errs);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int nw;
        int nr;
        int reads;

        // Reset state, with a request already pending
        s_tx_valid = 1'b1; s_tx_data = 8'hA5; uart_txrdy = 1'b1;
        repeat (2) step();
        mid();
        chk("rst_s_tx_ready", s_tx_ready, 1'b0);
        chk("rst_csn", uart_csn, 1'b1);
        chk("rst_wen", uart_wen, 1'b1);
        chk("rst_oen", uart_oen, 1'b1);
        chk("rst_wdata", uart_wdata, 8'h00);
        chk("rst_rx_valid", m_rx_valid, 1'b0);
        chk("rst_rx_data", m_rx_data, 8'h00);
        chk("rst_rx_err", m_rx_err, 3'b000);
        chk("rst_err_count", err_count, 8'h00);
        step();
        RESET_N = 1'b1;

        // Single write and TX blanking: accepts in cycles 0 and 4
        mid(); chk("t1_accept_c0", s_tx_ready, 1'b1);
        step(); s_tx_data = 8'h5A;
        mid();
        chk("t1_c1_csn", uart_csn, 1'b0);
        chk("t1_c1_wen", uart_wen, 1'b0);
        chk("t1_c1_wdata", uart_wdata, 8'hA5);
        chk("t1_c1_ready", s_tx_ready, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step(); mid();
            chk("t1_gap_ready", s_tx_ready, i == 4);
        end
        step(); s_tx_valid = 1'b0;
        mid();
        chk("t1_c5_wen", uart_wen, 1'b0);
        chk("t1_c5_wdata", uart_wdata, 8'h5A);
        repeat (4) step();

        // Read with a parity error, slot held while the consumer stalls
        uart_rxrdy = 1'b1; uart_rdata = 8'h3C; uart_parity_err = 1'b1; m_rx_ready = 1'b0;
        mid(); chk("t2_grant_csn_high", uart_csn, 1'b1);
        step(); mid();
        chk("t2_read_csn", uart_csn, 1'b0);
        chk("t2_read_oen", uart_oen, 1'b0);
        chk("t2_read_wen", uart_wen, 1'b1);
        step(); uart_parity_err = 1'b0; uart_rdata = 8'h81;
        mid();
        chk("t2_valid", m_rx_valid, 1'b1);
        chk("t2_data", m_rx_data, 8'h3C);
        chk("t2_err", m_rx_err, 3'b010);
        chk("t2_err_count", err_count, 8'd1);
        for (int i = 0; i < 8; i++) begin
            step(); mid();
            chk("t2_hold_oen", uart_oen, 1'b1);
            chk("t2_hold_data", m_rx_data, 8'h3C);
        end
        step(); m_rx_ready = 1'b1;
        step(); m_rx_ready = 1'b0;
        mid();
        chk("t2_pop_valid", m_rx_valid, 1'b0);
        chk("t2_reread_oen", uart_oen, 1'b0);
        step(); mid();
        chk("t2_refill_valid", m_rx_valid, 1'b1);
        chk("t2_refill_data", m_rx_data, 8'h81);
        chk("t2_refill_err", m_rx_err, 3'b000);
        step(); uart_rxrdy = 1'b0; m_rx_ready = 1'b1;
        repeat (5) step();

        // Continuous contention: TX and RX alternate, TX first
        s_tx_valid = 1'b1; uart_rxrdy = 1'b1; uart_rdata = 8'h42;
        nw = 0; nr = 0;
        for (int i = 0; i < 16; i++) begin
            s_tx_data = 8'(8'h10 + i);
            mid();
            chk("t3_wen_oen_excl", uart_wen | uart_oen, 1'b1);
            if (!uart_wen) begin
                chk("t3_order_w", nw, nr);
                nw++;
            end
            if (!uart_oen) begin
                chk("t3_order_r", nr + 1, nw);
                nr++;
            end
            step();
        end
        chk("t3_writes", nw, 4);
        chk("t3_reads", nr, 4);
        s_tx_valid = 1'b0; uart_rxrdy = 1'b0;
        repeat (6) step();

        // Error counter saturation
        uart_rxrdy = 1'b1; uart_overflow = 1'b1;
        reads = 0;
        for (int i = 0; i < 1200 && reads < 256; i++) begin
            mid();
            if (!uart_oen) reads++;
            step();
        end
        chk("t4_reads_done", reads, 256);
        uart_rxrdy = 1'b0;
        mid();
        chk("t4_err_sat", err_count, 8'd255);
        chk("t4_last_err", m_rx_err, 3'b001);
        step(); uart_overflow = 1'b0;
        repeat (5) step();

        // Asynchronous reset in the middle of a write
        s_tx_valid = 1'b1; s_tx_data = 8'hC3; uart_txrdy = 1'b1;
        mid(); chk("t5_accept", s_tx_ready, 1'b1);
        step(); mid();
        chk("t5_write_csn", uart_csn, 1'b0);
        chk("t5_write_wen", uart_wen, 1'b0);
        chk("t5_write_wdata", uart_wdata, 8'hC3);
        #1 RESET_N = 1'b0;
        #1;
        chk("t5_rst_csn", uart_csn, 1'b1);
        chk("t5_rst_wen", uart_wen, 1'b1);
        chk("t5_rst_oen", uart_oen, 1'b1);
        chk("t5_rst_wdata", uart_wdata, 8'h00);
        chk("t5_rst_rx_valid", m_rx_valid, 1'b0);
        chk("t5_rst_rx_data", m_rx_data, 8'h00);
        chk("t5_rst_err_count", err_count, 8'h00);
        chk("t5_rst_ready", s_tx_ready, 1'b0);
        uart_rxrdy = 1'b1; m_rx_ready = 1'b1;
        step(); step();
        RESET_N = 1'b1;
        mid(); chk("t5_tie_tx_first", s_tx_ready, 1'b1);
        step(); s_tx_valid = 1'b0;
        mid();
        chk("t5_tie_wen", uart_wen, 1'b0);
        chk("t5_tie_oen", uart_oen, 1'b1);
        step(); mid();
        step(); mid();
        chk("t5_then_read_oen", uart_oen, 1'b0);
        step(); uart_rxrdy = 1'b0;
        mid(); chk("t5_then_read_valid", m_rx_valid, 1'b1);
        repeat (6) step();

        // TX held off by uart_txrdy low
        s_tx_valid = 1'b1; s_tx_data = 8'h7E; uart_txrdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("t6_blocked_ready", s_tx_ready, 1'b0);
            chk("t6_blocked_wen", uart_wen, 1'b1);
            step();
        end
        uart_txrdy = 1'b1;
        mid(); chk("t6_accept", s_tx_ready, 1'b1);
        step(); s_tx_valid = 1'b0;
        mid();
        chk("t6_wen", uart_wen, 1'b0);
        chk("t6_wdata", uart_wdata, 8'h7E);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_host_if.md
# uart_host_if

Host-side driver for the UART core's CPU strobe interface (CSN/WEN/OEN, DATA_IN/DATA_OUT, TXRDY/RXRDY, error flags). It turns a valid/ready transmit byte stream into UART write strobes. It also polls RXRDY and issues UART read strobes, delivering received bytes with error flags on a valid/ready output. It sits between a processor or DMA-side byte FIFO and the UART instance, replacing software polling.

## Interface
- TX_BLANK, 2: cycles after a write strobe during which uart_txrdy is ignored; range 1..15.
- RX_BLANK, 2: cycles after a read strobe during which uart_rxrdy is ignored; range 1..15.
- CLK  in  1  system clock, same clock as the UART core.
- RESET_N  in  1  reset; asynchronous, active-low (already decided).
- s_tx_valid  in  1  host has a byte to transmit.
- s_tx_data  in  8  byte to transmit.
- s_tx_ready  out  1  byte accepted this cycle (combinational).
- m_rx_valid  out  1  received byte held in the output slot.
- m_rx_data  out  8  received byte.
- m_rx_err  out  3  {framing, parity, overflow}, captured with the byte.
- m_rx_ready  in  1  consumer takes the slot.
- err_count  out  8  saturating count of reads with any error bit set.
- uart_csn / uart_wen / uart_oen  out  1 each  active-low strobes to the UART.
- uart_wdata  out  8  byte to the UART DATA_IN.
- uart_rdata  in  8  UART DATA_OUT.
- uart_txrdy, uart_rxrdy, uart_parity_err, uart_framing_err, uart_overflow  in  1 each  UART status.

## Operation
- FSM states: IDLE, WRITE, READ. WRITE and READ each last exactly one cycle and always return to IDLE.
- Eligibility is evaluated in IDLE only:
  - tx_req = s_tx_valid & uart_txrdy & (tx_cnt==0).
  - rx_req = uart_rxrdy & (rx_cnt==0) & (!m_rx_valid | m_rx_ready).
- Arbitration:
  - Only one request → grant it.
  - Both → grant the opposite of last_grant (1-bit register, reset = RX, so TX wins the first tie).
  - last_grant updates on every grant.
- TX grant:
  - s_tx_ready=1 that cycle; s_tx_data registered into uart_wdata.
  - Next state WRITE: uart_csn=0, uart_wen=0.
  - tx_cnt is loaded with TX_BLANK at the end of the WRITE cycle.
- RX grant:
  - Next state READ: uart_csn=0, uart_oen=0.
  - In the READ cycle, uart_rdata and the three error inputs are sampled into m_rx_data/m_rx_err; m_rx_valid<=1.
  - err_count increments if any error bit is set, saturating at 255.
  - rx_cnt is loaded with RX_BLANK at the end of the READ cycle.
- Blank counters: 4-bit, decrement by 1 per cycle while nonzero, independent of each other and of FSM state. A read may therefore be granted during a TX blank, and a write during an RX blank.
- Output slot:
  - m_rx_valid clears on m_rx_valid & m_rx_ready.
  - A fill in READ and a pop in the same cycle leave m_rx_valid=1 with the new data.
  - m_rx_data/m_rx_err hold while valid and not popped.
- uart_wen and uart_oen are never low in the same cycle; uart_csn is low only in WRITE or READ.

## Timing
- Reset values:
  - uart_csn=uart_wen=uart_oen=1; uart_wdata=0.
  - m_rx_valid=0, m_rx_data=0, m_rx_err=0, err_count=0.
  - State=IDLE, tx_cnt=rx_cnt=0, last_grant=RX.
  - s_tx_ready=0 while RESET_N low.
- Strobe outputs are registered and glitch-free; an asynchronous reset mid-WRITE/READ forces the strobes high immediately and aborts the transfer with no output side effects.
- Write latency: handshake in cycle N → strobes low in N+1 → next write grant no earlier than N+2+TX_BLANK.
- Read latency: grant in cycle N → strobes low in N+1 → m_rx_valid visible at N+2. The next read grant is no earlier than N+2+RX_BLANK.
- Back-to-back TX with RX idle, TX_BLANK=2: one byte accepted every 4 cycles, provided uart_txrdy stays high.
- No combinational path from UART inputs to UART strobes; s_tx_ready depends combinationally on s_tx_valid, uart_txrdy, uart_rxrdy, m_rx_valid and m_rx_ready.

## Test plan
- Reset, then s_tx_valid=1, data 0xA5, uart_txrdy=1 → s_tx_ready in cycle 0; csn=wen=0, uart_wdata=0xA5 in cycle 1; no further grant until cycle 4 (TX_BLANK=2).
- uart_rxrdy=1, uart_rdata=0x3C, parity_err=1, m_rx_ready=0 → csn=oen=0 one cycle; m_rx_valid=1, data 0x3C, err=3'b010, err_count=1; with rxrdy held high, no second read until the consumer pops.
- s_tx_valid and uart_rxrdy both continuously high, m_rx_ready=1 → grants alternate TX, RX, TX, RX; wen and oen are never low together.
- Force 256 error reads → err_count stays at 255.
- Assert RESET_N low during the WRITE cycle → strobes return high in that cycle; all outputs take reset values; the first grant after release obeys the tie-break (TX first).
- uart_txrdy=0 with s_tx_valid=1 for 10 cycles → s_tx_ready stays 0 and wen stays high; raise txrdy → accept in the next IDLE cycle.
